rename_map_unit: RTL and testbench

//  Parametrised register-rename stage: RAT lookup for two sources, physical-destination

---
 rtl/rename_map_unit.sv | 192 +++++++++++++++++++
 tb/tb_rename_map_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_unit.sv
// rename_map_unit: RAT lookup, circular free-list preg allocation, busy table, commit-time free.
// Outputs registered (1 cycle); inst_ready_o low while free list empty. RENAME_FLUSH_EN adds RRAT-based flush.
module rename_map_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int AREG_W    = $clog2(ARCH_REGS),
  parameter int PREG_W    = $clog2(PHYS_REGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [AREG_W-1:0] rs1_addr_i,
  input  logic [AREG_W-1:0] rs2_addr_i,
  input  logic [AREG_W-1:0] rd_addr_i,
  input  logic              rd_we_i,
  output logic              out_valid_o,
  output logic [PREG_W-1:0] prs1_addr_o,
  output logic [PREG_W-1:0] prs2_addr_o,
  output logic              prs1_busy_o,
  output logic              prs2_busy_o,
  output logic [PREG_W-1:0] prd_addr_o,
  output logic [PREG_W-1:0] old_prd_addr_o,
  input  logic              cdb_en_i,
  input  logic [PREG_W-1:0] cdb_preg_addr_i,
  input  logic              commit_en_i,
  input  logic              commit_rd_we_i,
  input  logic [PREG_W-1:0] commit_old_prd_i,
`ifdef RENAME_FLUSH_EN
  input  logic              flush_i,
  input  logic [AREG_W-1:0] commit_rd_addr_i,
  input  logic [PREG_W-1:0] commit_prd_i,
`endif
  output logic [PREG_W:0]   free_count_o
);

  localparam int              FL_INIT = PHYS_REGS - ARCH_REGS;
  localparam logic [PREG_W:0] FL_MAX  = (PREG_W+1)'(FL_INIT);
  localparam logic [PREG_W:0] CNT_ONE = (PREG_W+1)'(1);
  localparam logic [PREG_W-1:0] PTR_ONE = PREG_W'(1);

  logic [PREG_W-1:0]    rat_q [ARCH_REGS];
  logic [PREG_W-1:0]    fl_q  [PHYS_REGS];
  logic [PHYS_REGS-1:0] busy_q;
  logic [PHYS_REGS-1:0] busy_nxt;
  logic [PREG_W-1:0]    head_q;
  logic [PREG_W-1:0]    tail_q;
  logic [PREG_W:0]      count_q;

  logic                 flush;
  logic                 accept;
  logic                 alloc;
  logic                 free_req;
  logic                 free_ok;
  logic [PREG_W-1:0]    alloc_preg;
  logic [PREG_W-1:0]    prs1;
  logic [PREG_W-1:0]    prs2;
  logic                 prs1_busy;
  logic                 prs2_busy;
  logic [PREG_W-1:0]    old_prd;
  logic [PREG_W-1:0]    head_nxt;
  logic [PREG_W-1:0]    tail_nxt;
  logic [PREG_W:0]      count_nxt;

  assign inst_ready_o = (count_q != '0);
  assign free_count_o = count_q;

  assign accept   = inst_valid_i & inst_ready_o & ~flush;
  assign alloc    = accept & rd_we_i & (rd_addr_i != '0);
  assign free_req = commit_en_i & commit_rd_we_i & (commit_old_prd_i != '0);
  // A free into a full list is a protocol error; the entry is dropped.
  assign free_ok  = free_req & (count_q != FL_MAX);

  assign alloc_preg = fl_q[head_q];
  assign old_prd    = rat_q[rd_addr_i];

  // Sources read the RAT as it stood before this instruction's rd update.
  assign prs1      = (rs1_addr_i == '0) ? '0 : rat_q[rs1_addr_i];
  assign prs2      = (rs2_addr_i == '0) ? '0 : rat_q[rs2_addr_i];
  assign prs1_busy = busy_q[prs1] & ~(cdb_en_i & (cdb_preg_addr_i == prs1));
  assign prs2_busy = busy_q[prs2] & ~(cdb_en_i & (cdb_preg_addr_i == prs2));

  assign head_nxt = alloc   ? head_q + PTR_ONE : head_q;
  assign tail_nxt = free_ok ? tail_q + PTR_ONE : tail_q;

  always_comb begin
    count_nxt = count_q;
    if (free_ok && !alloc) begin
      count_nxt = count_q + CNT_ONE;
    end else if (alloc && !free_ok) begin
      count_nxt = count_q - CNT_ONE;
    end
  end

  always_comb begin
    busy_nxt = busy_q;
    if (cdb_en_i) begin
      busy_nxt[cdb_preg_addr_i] = 1'b0;
    end
    if (alloc) begin
      busy_nxt[alloc_preg] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

`ifdef RENAME_FLUSH_EN
  logic [PREG_W-1:0] rrat_q   [ARCH_REGS];
  logic [PREG_W-1:0] rrat_nxt [ARCH_REGS];
  logic [PREG_W-1:0] chead_q;
  logic [PREG_W-1:0] chead_nxt;
  logic              commit_adv;

  assign flush      = flush_i;
  assign commit_adv = commit_en_i & commit_rd_we_i;
  assign chead_nxt  = commit_adv ? chead_q + PTR_ONE : chead_q;

  always_comb begin
    rrat_nxt = rrat_q;
    if (commit_adv && (commit_rd_addr_i != '0)) begin
      rrat_nxt[commit_rd_addr_i] = commit_prd_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rrat_q[i] <= PREG_W'(i);
      end
      chead_q <= '0;
    end else begin
      rrat_q  <= rrat_nxt;
      chead_q <= chead_nxt;
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PREG_W'(i);
      end
      for (int i = 0; i < PHYS_REGS; i++) begin
        fl_q[i] <= (i < FL_INIT) ? PREG_W'(i + ARCH_REGS) : '0;
      end
      busy_q         <= '0;
      head_q         <= '0;
      tail_q         <= PREG_W'(FL_INIT);
      count_q        <= FL_MAX;
      out_valid_o    <= 1'b0;
      prs1_addr_o    <= '0;
      prs2_addr_o    <= '0;
      prs1_busy_o    <= 1'b0;
      prs2_busy_o    <= 1'b0;
      prd_addr_o     <= '0;
      old_prd_addr_o <= '0;
    end else begin
      if (free_ok) begin
        fl_q[tail_q] <= commit_old_prd_i;
      end
      if (alloc) begin
        rat_q[rd_addr_i] <= alloc_preg;
      end
      busy_q  <= busy_nxt;
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      count_q <= count_nxt;

      out_valid_o    <= accept;
      prs1_addr_o    <= accept ? prs1 : '0;
      prs2_addr_o    <= accept ? prs2 : '0;
      prs1_busy_o    <= accept & prs1_busy;
      prs2_busy_o    <= accept & prs2_busy;
      prd_addr_o     <= alloc ? alloc_preg : '0;
      old_prd_addr_o <= alloc ? old_prd : '0;
`ifdef RENAME_FLUSH_EN
      // Rewind to the committed state; uncommitted pregs rejoin the free list.
      if (flush) begin
        rat_q   <= rrat_nxt;
        busy_q  <= '0;
        head_q  <= chead_nxt;
        count_q <= {1'b0, tail_nxt - chead_nxt};
      end
`endif
    end
  end

  free_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(free_req && (count_q == FL_MAX)));

endmodule

// File: tb/tb_rename_map_unit.sv
// Bench for rename_map_unit: directed scenarios then random traffic against a queue-based model.
module tb_rename_map_unit;
  localparam int AR  = 32;
  localparam int PR  = 64;
  localparam int AW  = 5;
  localparam int PW  = 6;
  localparam int FLN = PR - AR;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_valid, inst_ready, rd_we, out_valid;
  logic          prs1_busy, prs2_busy, cdb_en, commit_en, commit_rd_we;
  logic [AW-1:0] rs1, rs2, rd;
  logic [PW-1:0] prs1, prs2, prd, old_prd, cdb_preg, commit_old;
  logic [PW:0]   free_count;
`ifdef RENAME_FLUSH_EN
  logic          flush;
  logic [AW-1:0] commit_rd;
  logic [PW-1:0] commit_prd;
`endif

  always #5 clk = ~clk;

  rename_map_unit #(.ARCH_REGS(AR), .PHYS_REGS(PR)) dut (
    .clk_i(clk), .reset_i(reset),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rd_addr_i(rd), .rd_we_i(rd_we),
    .out_valid_o(out_valid), .prs1_addr_o(prs1), .prs2_addr_o(prs2),
    .prs1_busy_o(prs1_busy), .prs2_busy_o(prs2_busy),
    .prd_addr_o(prd), .old_prd_addr_o(old_prd),
    .cdb_en_i(cdb_en), .cdb_preg_addr_i(cdb_preg),
    .commit_en_i(commit_en), .commit_rd_we_i(commit_rd_we), .commit_old_prd_i(commit_old),
`ifdef RENAME_FLUSH_EN
    .flush_i(flush), .commit_rd_addr_i(commit_rd), .commit_prd_i(commit_prd),
`endif
    .free_count_o(free_count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int prd; int old; int rd;} rob_t;
  int   m_rat [AR];
  int   m_rrat[AR];
  bit   m_busy[PR];
  int   m_fl[$];
  rob_t m_rob[$];

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < AR; i++) begin
      m_rat[i]  = i;
      m_rrat[i] = i;
    end
    for (int i = 0; i < PR; i++) m_busy[i] = 1'b0;
    m_fl.delete();
    for (int i = AR; i < PR; i++) m_fl.push_back(i);
    m_rob.delete();
  endtask

  task automatic idle();
    inst_valid = 0; rs1 = '0; rs2 = '0; rd = '0; rd_we = 0;
    cdb_en = 0; cdb_preg = '0; commit_en = 0; commit_rd_we = 0; commit_old = '0;
`ifdef RENAME_FLUSH_EN
    flush = 0; commit_rd = '0; commit_prd = '0;
`endif
  endtask

  // Commit the oldest in-flight rename, if any.
  task automatic drive_commit(input bit en);
    commit_en = 0; commit_rd_we = 0; commit_old = '0;
`ifdef RENAME_FLUSH_EN
    commit_rd = '0; commit_prd = '0;
`endif
    if (en && m_rob.size() > 0) begin
      commit_en = 1; commit_rd_we = 1; commit_old = PW'(m_rob[0].old);
`ifdef RENAME_FLUSH_EN
      commit_rd = AW'(m_rob[0].rd); commit_prd = PW'(m_rob[0].prd);
`endif
    end
  endtask

  task automatic do_reset();
    reset = 1; inst_valid = 1; rd_we = 1; rd = 5'd3; rs1 = 5'd3;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    idle();
    check("rst_valid", out_valid, 0);
    check("rst_prs1", prs1, 0);
    check("rst_prd", prd, 0);
    check("rst_old", old_prd, 0);
    check("rst_count", free_count, FLN);
    check("rst_ready", inst_ready, 1);
  endtask

  // One clock: predict from the model, advance the DUT, update the model, compare.
  task automatic step();
    bit acc, alc, fre, flushing, pop;
    int ep1, ep2, eb1, eb2, eprd, eold;
    rob_t e;
    check("ready", inst_ready, m_fl.size() != 0);
    flushing = 0;
`ifdef RENAME_FLUSH_EN
    flushing = flush;
`endif
    acc  = inst_valid && (m_fl.size() != 0) && !flushing;
    ep1  = acc ? ((rs1 == 0) ? 0 : m_rat[rs1]) : 0;
    ep2  = acc ? ((rs2 == 0) ? 0 : m_rat[rs2]) : 0;
    eb1  = (acc && m_busy[ep1] && !(cdb_en && cdb_preg == ep1)) ? 1 : 0;
    eb2  = (acc && m_busy[ep2] && !(cdb_en && cdb_preg == ep2)) ? 1 : 0;
    alc  = acc && rd_we && (rd != 0);
    eprd = alc ? m_fl[0] : 0;
    eold = alc ? m_rat[rd] : 0;
    fre  = commit_en && commit_rd_we && (commit_old != 0) && (m_fl.size() < FLN);
    pop  = commit_en && commit_rd_we && (m_rob.size() > 0);
    @(posedge clk);
    if (cdb_en) m_busy[cdb_preg] = 1'b0;
    if (pop) begin
`ifdef RENAME_FLUSH_EN
      if (m_rob[0].rd != 0) m_rrat[m_rob[0].rd] = m_rob[0].prd;
`endif
      void'(m_rob.pop_front());
    end
    if (alc) begin
      m_busy[eprd] = 1'b1;
      m_rat[rd] = eprd;
      void'(m_fl.pop_front());
      e.prd = eprd; e.old = eold; e.rd = int'(rd);
      m_rob.push_back(e);
    end
    if (fre) m_fl.push_back(int'(commit_old));
`ifdef RENAME_FLUSH_EN
    if (flushing) begin
      m_rat = m_rrat;
      for (int i = 0; i < PR; i++) m_busy[i] = 1'b0;
      for (int i = m_rob.size() - 1; i >= 0; i--) m_fl.push_front(m_rob[i].prd);
      m_rob.delete();
    end
`endif
    #1;
    check("out_valid", out_valid, acc);
    check("prs1", prs1, ep1);
    check("prs2", prs2, ep2);
    check("prs1_busy", prs1_busy, eb1);
    check("prs2_busy", prs2_busy, eb2);
    check("prd", prd, eprd);
    check("old_prd", old_prd, eold);
    check("free_count", free_count, m_fl.size());
  endtask

  initial begin
    idle();
    do_reset();

    inst_valid = 1; rs1 = 5'd3; rs2 = 5'd5; rd_we = 0;
    step();
    check("d1_prs1", prs1, 3);
    check("d1_prs2", prs2, 5);
    check("d1_busy", prs1_busy | prs2_busy, 0);
    check("d1_count", free_count, 32);

    rs1 = '0; rs2 = '0; rd = 5'd1; rd_we = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("d2_prd", prd, 32 + i);
      check("d2_old", old_prd, (i == 0) ? 1 : 31 + i);
    end
    check("d2_count", free_count, 29);

    rd = '0; rd_we = 1;
    step();
    check("d3_prd_x0", prd, 0);
    check("d3_count_x0", free_count, 29);
    rd = 5'd6; rd_we = 0;
    step();
    check("d3_prd_nowe", prd, 0);
    check("d3_old_nowe", old_prd, 0);

    do_reset();
    inst_valid = 1; rs1 = 5'd4; rs2 = 5'd4; rd = 5'd4; rd_we = 1;
    step();
    check("d4_prs1", prs1, 4);
    check("d4_prd", prd, 32);
    check("d4_old", old_prd, 4);
    rd_we = 0;
    step();
    check("d5_prs1", prs1, 32);
    check("d5_busy", prs1_busy, 1);
    cdb_en = 1; cdb_preg = 6'd32;
    step();
    check("d5_bypass", prs1_busy, 0);
    cdb_en = 0;
    step();
    check("d5_cleared", prs1_busy, 0);

    do_reset();
    inst_valid = 1; rd = 5'd7; rd_we = 1;
    for (int i = 0; i < FLN; i++) step();
    check("d6_ready", inst_ready, 0);
    check("d6_count", free_count, 0);
    drive_commit(1);
    check("d6_commit_old", commit_old, 7);
    step();
    check("d6_stall", out_valid, 0);
    check("d6_ready_back", inst_ready, 1);
    drive_commit(0);
    step();
    check("d6_reuse", prd, 7);

`ifdef RENAME_FLUSH_EN
    do_reset();
    inst_valid = 1; rd = 5'd2; rd_we = 1;
    for (int i = 0; i < 3; i++) step();
    inst_valid = 0;
    drive_commit(1);
    step();
    drive_commit(0);
    inst_valid = 1; flush = 1;
    step();
    check("f_beats_accept", out_valid, 0);
    check("f_count", free_count, 32);
    flush = 0; rs1 = 5'd2; rd = 5'd3;
    step();
    check("f_rat", prs1, 32);
    check("f_busy", prs1_busy, 0);
    check("f_prd", prd, 33);
`endif

    do_reset();
    for (int c = 0; c < 2000; c++) begin
      inst_valid = ($urandom_range(0, 3) != 0);
      rs1   = AW'($urandom);
      rs2   = AW'($urandom);
      rd    = AW'($urandom);
      rd_we = ($urandom_range(0, 3) != 0);
      cdb_en   = $urandom_range(0, 1) == 1;
      cdb_preg = PW'($urandom);
      if (m_fl.size() > 0 && cdb_preg == m_fl[0]) cdb_en = 0;
      drive_commit(((c / 250) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1));
      if (!commit_en && $urandom_range(0, 7) == 0) begin
        commit_en = 1; commit_rd_we = 0; commit_old = PW'($urandom_range(1, PR - 1));
      end
`ifdef RENAME_FLUSH_EN
      flush = ($urandom_range(0, 59) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
